// File: rtl/coef_buf_pkg.sv
// Shared definitions for the coefficient buffer controller: sizes, data width, FSM states.
// Data width follows `PIXEL_WIDTH (enc_defines.v); a default is supplied when it is not defined.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package coef_buf_pkg;

    localparam int unsigned COEF_BUF_DEPTH = 192;
    localparam int unsigned COEF_BUF_AW    = 8;
    localparam int unsigned COEF_BUF_DW    = `PIXEL_WIDTH * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } coef_buf_state_e;

endpackage

// File: rtl/coef_buf_skid.sv
// Two-entry read-side buffer: output register plus one skid entry, valid/ready on the output.
// The upstream never pushes into a full buffer, so the input has no ready.
module coef_buf_skid
    import coef_buf_pkg::*;
#(
    parameter int unsigned DW = COEF_BUF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_val,
    input  logic [DW-1:0] in_dat,
    input  logic          in_last,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat,
    output logic          out_last,
    output logic [1:0]    held
);

    logic          out_val_q;
    logic          out_last_q;
    logic [DW-1:0] out_dat_q;
    logic          skid_val_q;
    logic          skid_last_q;
    logic [DW-1:0] skid_dat_q;
    logic          pop;

    assign pop = out_val_q & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_dat_q   <= '0;
            skid_val_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_dat_q  <= '0;
        end else if (!out_val_q || pop) begin
            // Output slot frees up: the skid word (older) moves first, new data backfills it.
            if (skid_val_q) begin
                out_val_q   <= 1'b1;
                out_dat_q   <= skid_dat_q;
                out_last_q  <= skid_last_q;
                skid_val_q  <= in_val;
                skid_dat_q  <= in_dat;
                skid_last_q <= in_last;
            end else begin
                out_val_q   <= in_val;
                out_dat_q   <= in_dat;
                out_last_q  <= in_last;
            end
        end else if (in_val) begin
            skid_val_q  <= 1'b1;
            skid_dat_q  <= in_dat;
            skid_last_q <= in_last;
        end
    end

    assign out_val  = out_val_q;
    assign out_dat  = out_dat_q;
    assign out_last = out_val_q & out_last_q;
    assign held     = {1'b0, out_val_q} + {1'b0, skid_val_q};

endmodule

// File: rtl/coef_buf_ctrl.sv
// Coefficient buffer controller: fills a single-port RAM from the transform, then drains it in order.
// Optional nonzero-coefficient flag detection is enabled by defining COEF_BUF_CBF_EN.
module coef_buf_ctrl
    import coef_buf_pkg::*;
#(
    parameter int unsigned DEPTH = COEF_BUF_DEPTH,
    parameter int unsigned AW    = COEF_BUF_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [AW-1:0]          len_i,
    input  logic                   wr_val_i,
    output logic                   wr_rdy_o,
    input  logic [COEF_BUF_DW-1:0] wr_dat_i,
    output logic                   rd_val_o,
    input  logic                   rd_rdy_i,
    output logic [COEF_BUF_DW-1:0] rd_dat_o,
    output logic                   rd_last_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [AW-1:0]          ram_addr_o,
    output logic [COEF_BUF_DW-1:0] ram_dat_o,
    input  logic [COEF_BUF_DW-1:0] ram_dat_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cbf_o
);

    coef_buf_state_e state_q, state_d;
    logic [AW-1:0]   len_q, wr_cnt_q, rd_cnt_q, len_sat;
    logic            rd_pend_q, rd_pend_last_q;
    logic            wr_acc, rd_issue, rd_pop, start_acc;
    logic [1:0]      held;
    logic [2:0]      occ;
    logic            cbf_q;

    assign start_acc = (state_q == IDLE) && start_i;
    assign len_sat   = (len_i > AW'(DEPTH)) ? AW'(DEPTH) : len_i;
    assign wr_rdy_o  = (state_q == FILL);
    assign wr_acc    = wr_rdy_o && wr_val_i;
    assign rd_pop    = rd_val_o && rd_rdy_i;

    // Words held plus the read in flight; a slot freed by this cycle's pop can be reused at once.
    assign occ      = {1'b0, held} + {2'b0, rd_pend_q};
    assign rd_issue = (state_q == DRAIN) && (rd_cnt_q != len_q) && (occ < (rd_pop ? 3'd3 : 3'd2));

    always_comb begin
        state_d    = state_q;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_dat_o  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = (len_i == '0) ? DONE : FILL;
            end
            FILL: begin
                if (wr_acc) begin
                    ram_ce_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = wr_cnt_q;
                    ram_dat_o  = wr_dat_i;
                    if (wr_cnt_q == len_q - AW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    ram_ce_o   = 1'b1;
                    ram_addr_o = rd_cnt_q;
                end
                if (rd_pop && rd_last_o) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            len_q          <= '0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_pend_q      <= rd_issue;
            rd_pend_last_q <= rd_issue && (rd_cnt_q == len_q - AW'(1));
            if (start_acc) begin
                len_q    <= len_sat;
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end
            if (wr_acc)   wr_cnt_q <= wr_cnt_q + AW'(1);
            if (rd_issue) rd_cnt_q <= rd_cnt_q + AW'(1);
        end
    end

    coef_buf_skid #(
        .DW(COEF_BUF_DW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (rd_pend_q),
        .in_dat  (ram_dat_i),
        .in_last (rd_pend_last_q),
        .out_val (rd_val_o),
        .out_rdy (rd_rdy_i),
        .out_dat (rd_dat_o),
        .out_last(rd_last_o),
        .held    (held)
    );

`ifdef COEF_BUF_CBF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cbf_q <= 1'b0;
        else if (start_acc)                 cbf_q <= 1'b0;
        else if (wr_acc && wr_dat_i != '0)  cbf_q <= 1'b1;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cbf_q <= 1'b0;
        else        cbf_q <= 1'b1;
    end
`endif

    assign cbf_o  = cbf_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: doc/coef_buf_ctrl.md
COEF_BUF_CTRL -- requirements
Module: coef_buf_ctrl

Interface
REQ-001 Parameter: DEPTH, 192, number of buffer words (capacity of the coefficient RAM).
REQ-002 Parameter: AW, 8, RAM address width.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start_i  input  1  one-cycle pulse that starts a block; sampled in IDLE only.
REQ-006 Port: len_i  input  AW  word count of the block; sampled with start_i.
REQ-007 Port: wr_val_i / wr_rdy_o / wr_dat_i  in/out/in  1/1/`PIXEL_WIDTH*8  transform-side write stream.
REQ-008 Port: rd_val_o / rd_rdy_i / rd_dat_o / rd_last_o  out/in/out/out  1/1/`PIXEL_WIDTH*8/1  entropy-coder-side read stream.
REQ-009 Port: ram_ce_o / ram_we_o / ram_addr_o / ram_dat_o / ram_dat_i  out/out/out/out/in  1/1/AW/`PIXEL_WIDTH*8/`PIXEL_WIDTH*8  single-port RAM; read data valid one cycle after ce&&!we.
REQ-010 Port: busy_o / done_o / cbf_o  out/out/out  1/1/1  state not IDLE; one-cycle end pulse; any-nonzero flag.

Function
REQ-011 FSM states SHALL be IDLE, FILL, DRAIN, DONE.
REQ-012 IDLE->FILL on start_i; len_i 0 -> DONE directly; len_i > DEPTH saturates to DEPTH.
REQ-013 start_i outside IDLE SHALL be ignored.
REQ-014 FILL: wr_rdy_o=1; each wr_val_i&&wr_rdy_o drives ram_ce_o=1, ram_we_o=1, ram_addr_o=write count, ram_dat_o=wr_dat_i, combinationally in that same cycle.
REQ-015 Write addresses SHALL run 0..len-1 ascending; after the len-th accepted word, FILL->DRAIN next cycle, wr_rdy_o=0.
REQ-016 DRAIN: reads issued ascending 0..len-1 with ram_ce_o=1, ram_we_o=0; RAM never written in DRAIN.
REQ-017 Read path SHALL hold up to 2 words (output register + 1-entry skid) so that no word is lost or duplicated under arbitrary rd_rdy_i.
REQ-018 A read SHALL issue only if in-flight + held words < 2 after the current cycle's handshake.
REQ-019 With rd_rdy_i held high, rd_val_o SHALL rise 2 cycles after entering DRAIN and sustain 1 word/cycle.
REQ-020 rd_val_o high and rd_rdy_i low SHALL hold rd_dat_o and rd_last_o stable.
REQ-021 rd_last_o=1 exactly on word len-1.
REQ-022 Last word handshake -> DONE; DONE asserts done_o for one cycle -> IDLE.
REQ-023 busy_o=1 in FILL, DRAIN, DONE.
REQ-024 ram_ce_o=0 whenever no access is made (power).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counters 0, skid empty.
REQ-026 Reset values: wr_rdy_o 0, rd_val_o 0, rd_last_o 0, done_o 0, busy_o 0, cbf_o 0, ram_ce_o 0, ram_we_o 0, ram_addr_o 0.
REQ-027 Reset mid-block SHALL abandon the block; RAM contents not relied upon.

Configuration
REQ-028 Macro COEF_BUF_CBF_EN: defined -> cbf_o cleared on start_i, set when any accepted write word is nonzero, valid from DRAIN entry until next start_i.
REQ-029 Without COEF_BUF_CBF_EN, cbf_o SHALL be constant 1 after reset release, with no detection logic.

Structure
REQ-030 Shared package: COEF_BUF_DEPTH=192, COEF_BUF_AW=8, FSM state encoding; data width from `PIXEL_WIDTH in enc_defines.v.
REQ-031 Sub-module coef_buf_skid: the 2-entry output register/skid with valid/ready.

Verification
REQ-032 start_i, len_i=8, 8 words back-to-back, rd_rdy_i=1 -> writes addr 0..7, rd_dat_o in same order, rd_last_o on 8th, done_o one cycle after.
REQ-033 len_i=192, rd_rdy_i random 50% -> all 192 words exact order, no loss/duplicate, stable data while stalled.
REQ-034 len_i=0 -> DONE next cycle, done_o pulse, no RAM access.
REQ-035 len_i=250 -> exactly 192 words accepted and read, addr max 191.
REQ-036 rst_n low mid-DRAIN at word 5 of 32 -> all outputs reset values immediately; next start_i len 4 completes normally.
REQ-037 COEF_BUF_CBF_EN on: all-zero block -> cbf_o 0; one nonzero word -> cbf_o 1; off: cbf_o 1.
